// File: rtl/wb_ctrl_if.sv
// Execute-to-writeback bus for wb_ctrl: retiring instruction, dmem handshake
// and register-file writeback signals.
interface wb_ctrl_if;
  logic       instr_valid;
  logic [1:0] wb_src;
  logic       reg_wr;
  logic [4:0] rd;
  logic       flush;
  logic       dmem_ack;
  logic       dmem_req;
  logic       stall;
  logic [1:0] wb_sel;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic       load_fault;

  modport slave (
    input  instr_valid, wb_src, reg_wr, rd, flush, dmem_ack,
    output dmem_req, stall, wb_sel, rf_we, rf_waddr, load_fault
  );

  modport master (
    output instr_valid, wb_src, reg_wr, rd, flush, dmem_ack,
    input  dmem_req, stall, wb_sel, rf_we, rf_waddr, load_fault
  );
endinterface

// File: rtl/wb_ctrl.sv
// Writeback sequencer: one retiring instruction per cycle, loads sequenced
// through a dmem req/ack handshake with stall, timeout fault and flush kill.
module wb_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      rst,
  wb_ctrl_if.slave  bus
);

  typedef enum logic {RUN, LD_WAIT} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0] SRC_LOAD = 2'b01;

  state_e     state_q, state_d;
  logic       dmem_req_q, dmem_req_d;
  logic [1:0] wb_sel_q, wb_sel_d;
  logic       rf_we_q, rf_we_d;
  logic [4:0] rf_waddr_q, rf_waddr_d;
  logic       load_fault_q, load_fault_d;
  logic [7:0] cnt_q, cnt_d;
  logic       kill_q, kill_d;
  logic [4:0] ld_rd_q, ld_rd_d;

  logic stall;
  logic accept;
  logic is_load;

  assign stall   = (state_q == LD_WAIT);
  assign accept  = bus.instr_valid & ~stall & ~bus.flush;
  assign is_load = (bus.wb_src == SRC_LOAD) & bus.reg_wr;

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    wb_sel_d     = wb_sel_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    load_fault_d = 1'b0;
    cnt_d        = cnt_q;
    kill_d       = kill_q;
    ld_rd_d      = ld_rd_q;

    unique case (state_q)
      RUN: begin
        if (accept) begin
          if (is_load) begin
            state_d    = LD_WAIT;
            dmem_req_d = 1'b1;
            cnt_d      = '0;
            kill_d     = 1'b0;
            ld_rd_d    = bus.rd;
          end else begin
            wb_sel_d   = bus.wb_src;
            rf_waddr_d = bus.rd;
            rf_we_d    = bus.reg_wr & (bus.rd != '0);
          end
        end
      end
      LD_WAIT: begin
        if (bus.flush) kill_d = 1'b1;
        // A flush arriving with the ack still kills the in-flight load.
        if (bus.dmem_ack) begin
          state_d    = RUN;
          dmem_req_d = 1'b0;
          kill_d     = 1'b0;
          if (!(kill_q | bus.flush)) begin
            wb_sel_d   = SRC_LOAD;
            rf_waddr_d = ld_rd_q;
            rf_we_d    = (ld_rd_q != '0);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d      = RUN;
          dmem_req_d   = 1'b0;
          load_fault_d = 1'b1;
          kill_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      dmem_req_q   <= 1'b0;
      wb_sel_q     <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      load_fault_q <= 1'b0;
      cnt_q        <= '0;
      kill_q       <= 1'b0;
      ld_rd_q      <= '0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      wb_sel_q     <= wb_sel_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      load_fault_q <= load_fault_d;
      cnt_q        <= cnt_d;
      kill_q       <= kill_d;
      ld_rd_q      <= ld_rd_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.wb_sel     = wb_sel_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.load_fault = load_fault_q;

endmodule
